// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-seg driver.
// Double-buffered data, blanking, leading-zero suppression, PWM brightness.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
  input  logic [NUM_DIGITS-1:0]   DOTS_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_IN,
  input  logic                    LZ_SUPPRESS_IN,
  input  logic [3:0]              BRIGHT_IN,
  input  logic                    LOAD_IN,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    FRAME_OUT
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OW = CNT_W + 5;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [NUM_DIGITS-1:0][3:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0][3:0] ac_dig_q, ac_dig_d;
  logic [NUM_DIGITS-1:0] sh_dot_q, sh_dot_d;
  logic [NUM_DIGITS-1:0] sh_blk_q, sh_blk_d;
  logic [NUM_DIGITS-1:0] ac_dot_q, ac_dot_d;
  logic [NUM_DIGITS-1:0] ac_blk_q, ac_blk_d;

  logic [NUM_DIGITS-1:0] seg_q, seg_d;
  logic [7:0] hex_q, hex_d;
  logic frame_q, frame_d;

  logic slot_end, frame_end;
  logic [OW-1:0] on_w;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic [3:0] code;
  logic dot, blk;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    g = 7'h7F;
    unique case (c)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0011000;
      4'hA: g = 7'b1000111;
      4'hB: g = 7'b0101111;
      4'hC: g = 7'b0001110;
      4'hD: g = 7'b0011111;
      4'hE: g = 7'b0111001;
      4'hF: g = 7'b0110001;
    endcase
    return g;
  endfunction

  always_comb begin
    slot_end  = (presc_q == PRESC_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    presc_d   = slot_end ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end)
      idx_d = frame_end ? '0 : idx_q + 1'b1;
  end

  // Active takes the pre-edge shadow, so a boundary LOAD waits a frame.
  always_comb begin
    sh_dig_d = sh_dig_q;
    sh_dot_d = sh_dot_q;
    sh_blk_d = sh_blk_q;
    ac_dig_d = ac_dig_q;
    ac_dot_d = ac_dot_q;
    ac_blk_d = ac_blk_q;
    if (LOAD_IN) begin
      sh_dig_d = DIGITS_IN;
      sh_dot_d = DOTS_IN;
      sh_blk_d = BLANK_IN;
    end
    if (frame_end) begin
      ac_dig_d = sh_dig_q;
      ac_dot_d = sh_dot_q;
      ac_blk_d = sh_blk_q;
    end
  end

  always_comb begin : lz_scan
    logic za;
    za = 1'b1;
    lz_dark = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_dark[k] = za && (ac_dig_q[k] == 4'h0) && (k != 0);
      za = za && ((ac_dig_q[k] == 4'h0) || ac_blk_q[k]);
    end
  end

  always_comb begin
    code  = ac_dig_q[idx_q];
    dot   = ac_dot_q[idx_q];
    blk   = ac_blk_q[idx_q];
    on_w  = ((OW'(BRIGHT_IN) + OW'(1)) * OW'(REFRESH_DIV)) >> 4;
    seg_d = '1;
    if ((presc_q != '0) && (OW'(presc_q) < on_w))
      seg_d[idx_q] = 1'b0;
    if (blk)
      hex_d = 8'hFF;
    else if (LZ_SUPPRESS_IN && lz_dark[idx_q])
      hex_d = {~dot, 7'h7F};
    else
      hex_d = {~dot, glyph(code)};
    frame_d = frame_end;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q  <= '0;
      idx_q    <= '0;
      sh_dig_q <= '0;
      sh_dot_q <= '0;
      sh_blk_q <= '1;
      ac_dig_q <= '0;
      ac_dot_q <= '0;
      ac_blk_q <= '1;
      seg_q    <= '1;
      hex_q    <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      sh_dig_q <= sh_dig_d;
      sh_dot_q <= sh_dot_d;
      sh_blk_q <= sh_blk_d;
      ac_dig_q <= ac_dig_d;
      ac_dot_q <= ac_dot_d;
      ac_blk_q <= ac_blk_d;
      seg_q    <= seg_d;
      hex_q    <= hex_d;
      frame_q  <= frame_d;
    end
  end

  assign SEG_SELECT_OUT = seg_q;
  assign HEX_OUT        = hex_q;
  assign FRAME_OUT      = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver, 4 digits, 16 cycles per slot.
// Expected glyph bytes are hand-computed from the glyph table.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dots, blank;
  logic [3:0] bright;
  logic lz, load;
  logic [ND-1:0] seg;
  logic [7:0] hex;
  logic frame;

  int n_cmp = 0;
  int n_bad = 0;
  int fno = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .CNT_W(CW)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .DIGITS_IN(digits),
    .DOTS_IN(dots),
    .BLANK_IN(blank),
    .LZ_SUPPRESS_IN(lz),
    .BRIGHT_IN(bright),
    .LOAD_IN(load),
    .SEG_SELECT_OUT(seg),
    .HEX_OUT(hex),
    .FRAME_OUT(frame)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = frame;
    end
    chk("frame_seen", 32'(seen), 32'd1);
  endtask

  // Starts right after a FRAME_OUT sample; ends on the next one.
  task automatic check_frame(input logic [7:0] h0, input logic [7:0] h1,
                             input logic [7:0] h2, input logic [7:0] h3,
                             input int on, input int load_at);
    logic [7:0] hx [4];
    logic [3:0] es;
    int slot, p;
    hx = '{h0, h1, h2, h3};
    fno++;
    for (int j = 0; j < 64; j++) begin
      load = (j == load_at);
      @(posedge clk);
      #1;
      load = 1'b0;
      slot = j / 16;
      p = j % 16;
      es = 4'hF;
      if (p != 0 && p < on)
        es[slot] = 1'b0;
      chk($sformatf("f%0d_j%0d_seg", fno, j), 32'(seg), 32'(es));
      chk($sformatf("f%0d_j%0d_hex", fno, j), 32'(hex), 32'(hx[slot]));
      chk($sformatf("f%0d_j%0d_frm", fno, j), 32'(frame),
          32'(j == 63));
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    digits = '0;
    dots   = '0;
    blank  = '0;
    bright = 4'd15;
    lz     = 1'b0;
    load   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg), 32'hF);
    chk("rst_hex", 32'(hex), 32'hFF);
    chk("rst_frm", 32'(frame), 32'd0);
    step(3);
    @(negedge clk);
    rst_n = 1'b1;

    digits = 16'h1234;
    dots   = 4'b0100;
    wait_frame();
    check_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16, 20);

    digits = 16'h5678;
    check_frame(8'h99, 8'hB0, 8'h24, 8'hF9, 16, 20);

    digits = 16'h9999;
    check_frame(8'h80, 8'hF8, 8'h02, 8'h92, 16, 63);
    check_frame(8'h80, 8'hF8, 8'h02, 8'h92, 16, -1);

    digits = 16'h0070;
    dots   = 4'b0000;
    lz     = 1'b1;
    check_frame(8'h98, 8'h98, 8'h18, 8'h98, 16, 20);

    digits = 16'h0000;
    check_frame(8'hC0, 8'hF8, 8'hFF, 8'hFF, 16, 20);
    check_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 16, -1);

    lz = 1'b0;
    check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 16, -1);

    bright = 4'd3;
    check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4, -1);

    bright = 4'd0;
    check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1, -1);

    bright = 4'd7;
    digits = 16'hCDEF;
    blank  = 4'b0010;
    dots   = 4'b0010;
    check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8, 20);

    bright = 4'd15;
    check_frame(8'hB1, 8'hFF, 8'h9F, 8'h8E, 16, -1);

    step(10);
    chk("pre_rst_seg", 32'(seg), 32'hE);
    chk("pre_rst_hex", 32'(hex), 32'hB1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'hF);
    chk("mid_rst_hex", 32'(hex), 32'hFF);
    chk("mid_rst_frm", 32'(frame), 32'd0);
    step(3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame();
    check_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It is the successor to the single-digit combinational decoder. It owns its own refresh prescaler and digit scanning, and double-buffers the display data so frames never tear. It also adds per-digit blanking, leading-zero suppression and 16-level PWM brightness. It sits between the application logic (mouse status, counters) and the board's display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>=16)
CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
DIGITS_IN  in  4*NUM_DIGITS  glyph codes; nibble k drives digit k (k=0 is rightmost)
DOTS_IN  in  NUM_DIGITS  decimal point per digit, 1 = lit
BLANK_IN  in  NUM_DIGITS  1 = force digit k dark (segments and dot)
LZ_SUPPRESS_IN  in  1  1 = enable leading-zero suppression
BRIGHT_IN  in  4  brightness level, 15 = full on
LOAD_IN  in  1  1-cycle strobe that captures DIGITS/DOTS/BLANK into the shadow register
SEG_SELECT_OUT  out  NUM_DIGITS  anode enables, active-low, one-hot-low
HEX_OUT  out  8  [7] = dot, [6:0] = gfedcba; all active-low
FRAME_OUT  out  1  1-cycle pulse when digit index wraps to 0

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - SEG_SELECT_OUT = all 1, HEX_OUT = 8'hFF, FRAME_OUT = 0.
  - Prescaler = 0, digit index = 0.
  - Shadow and active registers = 0, with all blank bits set to 1.
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments modulo NUM_DIGITS.
  - When the digit index wraps NUM_DIGITS-1 -> 0, the active register is loaded from the shadow register in the same edge, and FRAME_OUT pulses for 1 cycle.
- LOAD_IN = 1 captures the inputs into the shadow register on that edge.
  - The captured data is displayed from the next frame start, never mid-frame.
  - If LOAD_IN coincides with a frame boundary, the active register takes the old shadow value. The new data appears one frame later.
- Glyph table, HEX_OUT[6:0] for codes 0..F:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000
  - A (L) = 1000111, B (R) = 0101111, C (F) = 0001110, D (B) = 0011111
  - E (FR) = 0111001, F (FL) = 0110001
- Leading-zero suppression, when LZ_SUPPRESS_IN = 1:
  - Digit k is dark (segments 1111111) if its code is 0 and every digit above k is also code 0 or blanked.
  - Digit 0 is never suppressed.
  - The dot of a suppressed digit still follows DOTS.
  - LZ_SUPPRESS_IN is sampled live, not buffered.
- Blanked digit: HEX_OUT = 8'hFF for its whole slot, and its anode stays asserted.
- Brightness:
  - ON = ((BRIGHT_IN+1)*REFRESH_DIV) >> 4, computed at full width before the shift.
  - The anode is asserted only while prescaler < ON. Otherwise SEG_SELECT_OUT = all 1.
  - BRIGHT_IN = 15 gives ON = REFRESH_DIV, i.e. always on.
  - BRIGHT_IN is sampled live.
- Ghost guard: for the first cycle of every slot (prescaler = 0), SEG_SELECT_OUT = all 1 regardless of brightness.
- All outputs are registered. Outputs reflect the prescaler and digit state of the previous cycle, giving 1 cycle of latency.
- Digit index k drives SEG_SELECT_OUT bit k low; all other bits are high. Two anodes are never low in the same cycle.

Test Plan:
- Reset and default: sim with REFRESH_DIV=16, NUM_DIGITS=4. Assert RESET_N=0 mid-scan -> outputs are immediately all 1 (8'hFF, 4'hF). No digit lights until a LOAD_IN and a frame boundary.
- Scan order and content: load DIGITS=16'h1234, DOTS=4'b0100, BLANK=0, BRIGHT=15 -> anodes cycle 1110, 1101, 1011, 0111, each for 15 cycles after the 1-cycle guard. HEX_OUT shows 0011001, 0110000, 0100100 (dot lit, [7]=0), 1111001. FRAME_OUT pulses every 64 cycles.
- Double buffering: pulse LOAD_IN with 16'h5678 mid-frame -> the current frame completes showing 1234, and 5678 starts at the next FRAME_OUT. A LOAD_IN on the boundary cycle defers the new data by one frame.
- Leading zeros: DIGITS=16'h0070, LZ=1 -> digits 3 and 2 are dark, digit 1 shows 7, digit 0 shows 0. With DIGITS=16'h0000, digit 0 shows 0. With LZ=0, all digits show 0.
- Brightness: BRIGHT=3 -> ON=4, so the anode is low on prescaler 1..3 of each slot. BRIGHT=0 -> ON=1, so the anode is never low (guard overrides). BRIGHT=7 -> ON=8.
- Blank and glyphs: BLANK=4'b0010 with DIGITS=16'hCDEF -> digit 1 is dark with its dot off even if DOTS[1]=1. Digits 0, 2 and 3 show 0110001, 0011111 and 0001110 respectively.
